// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the pipeline. It takes the EX/MEM register outputs, runs loads
// and stores over a req/ack data-memory port with variable latency, stalls the
// front of the pipeline while an access is outstanding, and holds the MEM/WB
// pipeline register.
//
// Handshake: mem_req rises on the edge that enters WAIT. mem_req, mem_we,
// mem_addr and mem_wdata then stay stable until the edge where mem_ack is
// sampled high. That edge completes the access and drops mem_req. mem_rdata is
// only looked at on that edge. A mem_ack seen in IDLE is ignored.
//
// Optional feature (macro MEM_TIMEOUT_EN): a WAIT-cycle counter abandons an
// access after TIMEOUT_CYCLES cycles without mem_ack and sets the sticky
// mem_err flag. When the macro is undefined, WAIT lasts until mem_ack and
// mem_err is tied to 0.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   RegWrite, MemtoReg,
//   MemWrite, MemRead,
//   Result, RtData, MuxIn EX/MEM register outputs (Result is also the address)
//   mem_rdata, mem_ack    memory read data and completion strobe
//   mem_req, mem_we,
//   mem_addr, mem_wdata   registered memory request
//   stall                 combinational; freezes PC, IF/ID, ID/EX, EX/MEM
//   mem_err               sticky timeout flag
//   RegWriteOut, MemtoRegOut, ReadDataOut, ResultOut, MuxOut   MEM/WB register
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Result,
  input  logic [31:0] RtData,
  input  logic [4:0]  MuxIn,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        mem_err,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ResultOut,
  output logic [4:0]  MuxOut
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Exposed for checkers to bind to.
  state_t state;

  logic access;
  logic timeout;

  // A store that also has MemRead set is treated as a store.
  assign access = MemRead | MemWrite;

  // Empty marker block that is generated only for an illegal TIMEOUT_CYCLES
  // (legal range 1..65535).
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_illegal
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        err_q;

  // Last permitted WAIT cycle with no ack. A same-cycle ack wins.
  assign timeout = (state == WAIT) && !mem_ack && (wait_cnt == TIMEOUT_LAST);
  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Stall is low on the completing (or abandoning) cycle, so EX/MEM advances
  // on the same edge that MEM/WB captures the instruction.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    stall = access;
        WAIT:    stall = ~mem_ack & ~timeout;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      RegWriteOut <= 1'b0;
      MemtoRegOut <= 1'b0;
      ReadDataOut <= 32'd0;
      ResultOut   <= 32'd0;
      MuxOut      <= 5'd0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt    <= 16'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state       <= WAIT;
            mem_req     <= 1'b1;
            mem_we      <= MemWrite;
            mem_addr    <= Result;
            mem_wdata   <= RtData;
            RegWriteOut <= 1'b0;
            MemtoRegOut <= 1'b0;
            ReadDataOut <= 32'd0;
            ResultOut   <= 32'd0;
            MuxOut      <= 5'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= 16'd0;
`endif
          end else begin
            RegWriteOut <= RegWrite;
            MemtoRegOut <= MemtoReg;
            ReadDataOut <= 32'd0;
            ResultOut   <= Result;
            MuxOut      <= MuxIn;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            RegWriteOut <= RegWrite;
            MemtoRegOut <= MemtoReg;
            // mem_we was captured from the same, frozen, EX/MEM contents.
            ReadDataOut <= mem_we ? 32'd0 : mem_rdata;
            ResultOut   <= Result;
            MuxOut      <= MuxIn;
`ifdef MEM_TIMEOUT_EN
          end else if (timeout) begin
            // Abandoned access retires without a register write.
            state       <= IDLE;
            mem_req     <= 1'b0;
            err_q       <= 1'b1;
            RegWriteOut <= 1'b0;
            MemtoRegOut <= MemtoReg;
            ReadDataOut <= 32'd0;
            ResultOut   <= Result;
            MuxOut      <= MuxIn;
`endif
          end else begin
            RegWriteOut <= 1'b0;
            MemtoRegOut <= 1'b0;
            ReadDataOut <= 32'd0;
            ResultOut   <= 32'd0;
            MuxOut      <= 5'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= wait_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed per-cycle vectors. Each cycle, the driver applies inputs at the
// falling edge and pushes the hand-computed observation for that cycle. The
// observation is:
//   - registered outputs left by the previous rising edge, and
//   - the combinational stall for the newly applied inputs.
// A separate monitor samples just before the next rising edge, pops one
// expected record and compares it.
// The timeout vectors are built only with MEM_TIMEOUT_EN. For those vectors
// TIMEOUT_CYCLES is 4.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int W = 139;

  logic        clk;
  logic        rst_n;
  logic        RegWrite, MemtoReg, MemWrite, MemRead;
  logic [31:0] Result, RtData, mem_rdata;
  logic [4:0]  MuxIn;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, mem_err;
  logic [31:0] mem_addr, mem_wdata;
  logic        RegWriteOut, MemtoRegOut;
  logic [31:0] ReadDataOut, ResultOut;
  logic [4:0]  MuxOut;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_total = 0;
  int           n_pass  = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
    .Result(Result), .RtData(RtData), .MuxIn(MuxIn),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .mem_err(mem_err),
    .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut), .ReadDataOut(ReadDataOut),
    .ResultOut(ResultOut), .MuxOut(MuxOut)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge.
  task automatic drv(input logic rst, input logic rw, input logic m2r, input logic mw,
                     input logic mr, input logic [31:0] res, input logic [31:0] rt,
                     input logic [4:0] mux, input logic ack, input logic [31:0] rd);
    @(negedge clk);
    rst_n = rst; RegWrite = rw; MemtoReg = m2r; MemWrite = mw; MemRead = mr;
    Result = res; RtData = rt; MuxIn = mux; mem_ack = ack; mem_rdata = rd;
  endtask

  // Push the expected observation for the cycle just driven.
  task automatic expect_obs(input string tag, input logic st, input logic req,
                            input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic err, input logic rw,
                            input logic m2r, input logic [31:0] rdat,
                            input logic [31:0] res, input logic [4:0] mux);
    exp_q.push_back({st, req, we, addr, wd, err, rw, m2r, rdat, res, mux});
    tag_q.push_back(tag);
  endtask

  // Monitor / scoreboard.
  initial begin
    logic [W-1:0] got, exp_v;
    string        tag;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        got   = {stall, mem_req, mem_we, mem_addr, mem_wdata, mem_err,
                 RegWriteOut, MemtoRegOut, ReadDataOut, ResultOut, MuxOut};
        n_total++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp_v);
      end
    end
  end

  // Stimulus. Field order for expect_obs:
  //   stall, req, we, addr, wdata, err, RegWriteOut, MemtoRegOut,
  //   ReadDataOut, ResultOut, MuxOut
  initial begin
    rst_n = 1'b0; RegWrite = 0; MemtoReg = 0; MemWrite = 0; MemRead = 0;
    Result = 0; RtData = 0; MuxIn = 0; mem_ack = 0; mem_rdata = 0;

    drv(0, 0,0,0,0, 32'h0,   32'h0, 5'd0, 0, 32'h0);
    drv(0, 0,0,0,0, 32'h0,   32'h0, 5'd0, 0, 32'h0);
    expect_obs("reset_init", 0,0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    // ALU op, no access
    drv(1, 1,0,0,0, 32'hA5,  32'h0, 5'd9, 0, 32'h0);
    expect_obs("alu_issue",  0,0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    // Load, three WAIT cycles without ack, ack on the fourth
    drv(1, 1,1,0,1, 32'h100, 32'h0, 5'd4, 0, 32'h0);
    expect_obs("alu_wb",     1,0,0,32'h0,32'h0,0, 1,0,32'h0,32'hA5,5'd9);
    drv(1, 1,1,0,1, 32'h100, 32'h0, 5'd4, 0, 32'h0);
    expect_obs("ld_wait1",   1,1,0,32'h100,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(1, 1,1,0,1, 32'h100, 32'h0, 5'd4, 0, 32'h0);
    expect_obs("ld_wait2",   1,1,0,32'h100,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(1, 1,1,0,1, 32'h100, 32'h0, 5'd4, 0, 32'h0);
    expect_obs("ld_wait3",   1,1,0,32'h100,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(1, 1,1,0,1, 32'h100, 32'h0, 5'd4, 1, 32'hDEADBEEF);
    expect_obs("ld_ack",     0,1,0,32'h100,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    // Store, ack on first WAIT cycle
    drv(1, 0,0,1,0, 32'h20,  32'h1234, 5'd0, 0, 32'h0);
    expect_obs("ld_wb",      1,0,0,32'h100,32'h0,0, 1,1,32'hDEADBEEF,32'h100,5'd4);
    drv(1, 0,0,1,0, 32'h20,  32'h1234, 5'd0, 1, 32'h55);
    expect_obs("st_ack",     0,1,1,32'h20,32'h1234,0, 0,0,32'h0,32'h0,5'd0);
    // Back-to-back load re-enters through IDLE
    drv(1, 1,1,0,1, 32'h44,  32'h0, 5'd7, 0, 32'h0);
    expect_obs("st_wb",      1,0,1,32'h20,32'h1234,0, 0,0,32'h0,32'h20,5'd0);
    drv(1, 1,1,0,1, 32'h44,  32'h0, 5'd7, 1, 32'hCAFEF00D);
    expect_obs("ld2_ack",    0,1,0,32'h44,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    // MemRead and MemWrite both set: a write
    drv(1, 0,0,1,1, 32'h88,  32'hAB, 5'd3, 0, 32'h0);
    expect_obs("ld2_wb",     1,0,0,32'h44,32'h0,0, 1,1,32'hCAFEF00D,32'h44,5'd7);
    drv(1, 0,0,1,1, 32'h88,  32'hAB, 5'd3, 1, 32'hFFFF);
    expect_obs("rw_ack",     0,1,1,32'h88,32'hAB,0, 0,0,32'h0,32'h0,5'd0);
    // Spurious ack in IDLE
    drv(1, 1,0,0,0, 32'h77,  32'h0, 5'd2, 1, 32'h1111);
    expect_obs("rw_wb",      0,0,1,32'h88,32'hAB,0, 0,0,32'h0,32'h88,5'd3);
    // Load, then reset in WAIT, then a late ack
    drv(1, 1,1,0,1, 32'h200, 32'h0, 5'd5, 0, 32'h0);
    expect_obs("spur_wb",    1,0,1,32'h88,32'hAB,0, 1,0,32'h0,32'h77,5'd2);
    drv(1, 1,1,0,1, 32'h200, 32'h0, 5'd5, 0, 32'h0);
    expect_obs("rst_wait",   1,1,0,32'h200,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(0, 1,1,0,1, 32'h200, 32'h0, 5'd5, 0, 32'h0);
    expect_obs("rst_stall0", 0,1,0,32'h200,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(0, 1,1,0,1, 32'h200, 32'h0, 5'd5, 1, 32'h0);
    expect_obs("rst_clear",  0,0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(1, 0,0,0,0, 32'h0,   32'h0, 5'd0, 1, 32'hABCD);
    expect_obs("late_ack",   0,0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(1, 0,0,0,0, 32'h0,   32'h0, 5'd0, 0, 32'h0);
    expect_obs("late_ack_wb",0,0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0,5'd0);
`ifdef MEM_TIMEOUT_EN
    // Load that is never acked: four WAIT cycles, then abandoned
    drv(1, 1,1,0,1, 32'h300, 32'h0, 5'd6, 0, 32'h0);
    expect_obs("to_issue",   1,0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1,1,0,1, 32'h300, 32'h0, 5'd6, 0, 32'h0);
      expect_obs("to_wait",  1,1,0,32'h300,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    end
    drv(1, 1,1,0,1, 32'h300, 32'h0, 5'd6, 0, 32'h0);
    expect_obs("to_last",    0,1,0,32'h300,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(0, 0,0,0,0, 32'h0,   32'h0, 5'd0, 0, 32'h0);
    expect_obs("to_err",     0,0,0,32'h300,32'h0,1, 0,1,32'h0,32'h300,5'd6);
    // Same load acked in the fourth WAIT cycle: normal completion
    drv(1, 1,1,0,1, 32'h400, 32'h0, 5'd8, 0, 32'h0);
    expect_obs("to2_issue",  1,0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1,1,0,1, 32'h400, 32'h0, 5'd8, 0, 32'h0);
      expect_obs("to2_wait", 1,1,0,32'h400,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    end
    drv(1, 1,1,0,1, 32'h400, 32'h0, 5'd8, 1, 32'h12345678);
    expect_obs("to2_ack",    0,1,0,32'h400,32'h0,0, 0,0,32'h0,32'h0,5'd0);
    drv(1, 0,0,0,0, 32'h0,   32'h0, 5'd0, 0, 32'h0);
    expect_obs("to2_wb",     0,0,0,32'h400,32'h0,0, 1,1,32'h12345678,32'h400,5'd8);
`endif
    // Let the monitor drain the queue, bounded by a cycle budget.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #6;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
